pc_seq: RTL



---
 rtl/pc_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pc_seq.sv
// Fetch sequencer: owns the fetch PC, issues one imem request at a time, hands instructions to decode.
// Optional misaligned-redirect fault detection is enabled by defining PC_SEQ_ALIGN_CHK_EN.
module pc_seq #(
   parameter int unsigned         PC_W     = 8,
   parameter logic [PC_W-1:0]     RESET_PC = 8'h00,
   parameter int unsigned         PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            halt,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [PC_W-1:0] if_pc,
   output logic [31:0]     if_instr,
   input  logic            id_ready,
   input  logic            redir_valid,
   input  logic [PC_W-1:0] redir_pc,
   output logic            busy,
   output logic            fault
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            req_q, req_d;
   logic            busy_q, busy_d;
   logic            if_valid_q, if_valid_d;
   logic [PC_W-1:0] if_pc_q, if_pc_d;
   logic [31:0]     if_instr_q, if_instr_d;
   logic            fault_q, fault_d;

   logic            redir_bad_c;
   logic [PC_W-1:0] redir_tgt_c;

`ifdef PC_SEQ_ALIGN_CHK_EN
   assign redir_bad_c = |redir_pc[1:0];
   assign redir_tgt_c = redir_pc;
`else
   // Low address bits are forced to zero so every target is word aligned.
   assign redir_bad_c = 1'b0;
   assign redir_tgt_c = redir_pc & ~PC_W'(3);
`endif

   // Next-state, PC and decode-handoff logic; redirect outranks every other event while busy.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      fault_d    = fault_q;

      unique case (state_q)
         IDLE, HALTED: begin
            if (start) begin
               state_d = FETCH;
               if (state_q == HALTED) fault_d = 1'b0;
            end
            if (redir_valid) begin
               if (redir_bad_c) begin
                  state_d = HALTED;
                  fault_d = 1'b1;
               end else begin
                  pc_d = redir_tgt_c;
               end
            end
         end
         FETCH, HOLD: begin
            if (redir_valid) begin
               if_valid_d = 1'b0;
               if (redir_bad_c) begin
                  state_d = HALTED;
                  fault_d = 1'b1;
               end else begin
                  state_d = FETCH;
                  pc_d    = redir_tgt_c;
               end
            end else if (state_q == FETCH) begin
               if (imem_ack) begin
                  if_instr_d = imem_rdata;
                  if_pc_d    = pc_q;
                  if_valid_d = 1'b1;
                  pc_d       = pc_q + PC_W'(PC_STEP);
                  state_d    = HOLD;
               end else if (halt) begin
                  state_d = HALTED;
               end
            end else if (id_ready) begin
               if_valid_d = 1'b0;
               state_d    = halt ? HALTED : FETCH;
            end
         end
      endcase

      req_d  = (state_d == FETCH);
      busy_d = (state_d == FETCH) || (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         fault_q    <= fault_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_instr  = if_instr_q;
   assign busy      = busy_q;
   assign fault     = fault_q;

endmodule
